// File: rtl/risc16_mem.sv
// Shared instruction/data memory plus load/hold/run sequencer for the risc16b core.
// Optional memory-mapped output register at byte 0xFFFE/0xFFFF: define RISC16_MEM_MMIO_EN.
module risc16_mem #(
  parameter int unsigned ADDR_W   = 13,
  parameter int unsigned RST_HOLD = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] i_addr,
  input  logic        i_oe,
  output logic [15:0] i_din,
  input  logic [15:0] d_addr,
  input  logic        d_oe,
  output logic [15:0] d_din,
  input  logic [15:0] d_dout,
  input  logic [1:0]  d_we,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [15:0] ld_addr,
  input  logic [15:0] ld_data,
  input  logic        ld_last,
  output logic        cpu_rst,
  output logic        running,
  output logic [15:0] mmio_out,
  output logic        mmio_valid
);

  localparam int unsigned IdxW  = ADDR_W - 1;
  localparam int unsigned Words = 1 << IdxW;

  typedef enum logic [1:0] {StLoad, StHold, StRun} state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;

  logic [15:0]     mem [Words];
  logic [IdxW-1:0] i_idx, d_idx, ld_idx;
  logic            ld_fire, st_en, d_is_mmio;

  assign i_idx  = i_addr[ADDR_W-1:1];
  assign d_idx  = d_addr[ADDR_W-1:1];
  assign ld_idx = ld_addr[ADDR_W-1:1];

  // Untranslated high address bits and ld_addr[0] are don't-care by design.
  logic unused_bits;
  assign unused_bits = ^{i_addr, d_addr, ld_addr};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StLoad;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StLoad: begin
        if (ld_fire && ld_last) begin
          state_d = StHold;
          cnt_d   = 8'(RST_HOLD - 1);
        end
      end
      StHold: begin
        if (cnt_q == 8'd0) state_d = StRun;
        else               cnt_d   = cnt_q - 8'd1;
      end
      StRun:   state_d = StRun;
      default: state_d = StLoad;
    endcase
  end

  // Outputs decoded from the state register only
  always_comb begin
    ld_ready = 1'b0;
    cpu_rst  = 1'b1;
    running  = 1'b0;
    unique case (state_q)
      StLoad:  ld_ready = 1'b1;
      StHold:  cpu_rst  = 1'b1;
      StRun: begin
        cpu_rst = 1'b0;
        running = 1'b1;
      end
      default: ld_ready = 1'b0;
    endcase
  end

  assign ld_fire = ld_valid & ld_ready & ~rst;
  assign st_en   = running & (|d_we) & ~rst;

`ifdef RISC16_MEM_MMIO_EN
  assign d_is_mmio = (d_addr[15:1] == 15'h7FFF);

  always_ff @(posedge clk) begin
    if (rst) begin
      mmio_out   <= '0;
      mmio_valid <= 1'b0;
    end else begin
      mmio_valid <= st_en & d_is_mmio;
      if (st_en && d_is_mmio) begin
        if (d_we[0]) mmio_out[15:8] <= d_dout[15:8];
        if (d_we[1]) mmio_out[7:0]  <= d_dout[7:0];
      end
    end
  end
`else
  assign d_is_mmio  = 1'b0;
  assign mmio_out   = '0;
  assign mmio_valid = 1'b0;
`endif

  // Array is never cleared; load and store writes are exclusive by state.
  always_ff @(posedge clk) begin
    if (ld_fire) begin
      mem[ld_idx] <= ld_data;
    end
    if (st_en && !d_is_mmio) begin
      if (d_we[0]) mem[d_idx][15:8] <= d_dout[15:8];
      if (d_we[1]) mem[d_idx][7:0]  <= d_dout[7:0];
    end
  end

  assign i_din = i_oe ? mem[i_idx] : 16'h0000;
  assign d_din = !d_oe    ? 16'h0000 :
                 d_is_mmio ? mmio_out : mem[d_idx];

endmodule
